// File: rtl/mw_mem_write_ctrl_if.sv
// MW store-side and memory bus-side bundles for mw_mem_write_ctrl.
// Store side: MW is master; bus side: the write controller is master.
interface mw_store_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              v_mem_we;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [1:0]        wr_size;
  logic              write_finished;
  logic              wr_busy;

  modport master (
    output v_mem_we, wr_addr, wr_data, wr_size,
    input  write_finished, wr_busy
  );
  modport slave (
    input  v_mem_we, wr_addr, wr_data, wr_size,
    output write_finished, wr_busy
  );
endinterface

interface mw_bus_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              bus_req;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_data;
  logic [3:0]        bus_be;
  logic              bus_ack;

  modport master (
    output bus_req, bus_addr, bus_data, bus_be,
    input  bus_ack
  );
  modport slave (
    input  bus_req, bus_addr, bus_data, bus_be,
    output bus_ack
  );
endinterface

// File: rtl/mw_mem_write_ctrl.sv
// MW memory write port: splits 1/2/4B stores into aligned bus beats.
// Optional posted completion under `define MW_POSTED_WRITE_EN.
module mw_mem_write_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic      clk,
  input logic      rst,
  mw_store_if.slave st,
  mw_bus_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE,
    BEAT1,
    BEAT2,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [3:0]        be_q, be_d;
  logic              wf_q, wf_d;
  logic              busy_q, busy_d;

  logic [ADDR_W-1:0] hi_addr_q;
  logic [DATA_W-1:0] hi_data_q;
  logic [3:0]        hi_be_q;
  logic              cross_q;
  logic              latch_en;

  logic [1:0]          off;
  logic [3:0]          nbytes;
  logic [3:0]          mask;
  logic                cross_in;
  logic [7:0]          wide_be;
  logic [2*DATA_W-1:0] wide_data;
  logic [ADDR_W-1:0]   aligned;

  assign off = st.wr_addr[1:0];

  always_comb begin
    nbytes = 4'd4;
    mask   = 4'b1111;
    unique case (st.wr_size)
      2'd0: begin
        nbytes = 4'd1;
        mask   = 4'b0001;
      end
      2'd1: begin
        nbytes = 4'd2;
        mask   = 4'b0011;
      end
      default: begin
        nbytes = 4'd4;
        mask   = 4'b1111;
      end
    endcase
  end

  // Lanes spilling past byte 3 land in the upper half: that is beat 2
  assign cross_in  = ({2'b00, off} + nbytes) > 4'd4;
  assign wide_be   = {4'b0000, mask} << off;
  assign wide_data = {{DATA_W{1'b0}}, st.wr_data} << {off, 3'b000};
  assign aligned   = {st.wr_addr[ADDR_W-1:2], 2'b00};

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    addr_d   = addr_q;
    data_d   = data_q;
    be_d     = be_q;
    wf_d     = 1'b0;
    latch_en = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (st.v_mem_we) begin
          state_d  = BEAT1;
          req_d    = 1'b1;
          addr_d   = aligned;
          data_d   = wide_data[DATA_W-1:0];
          be_d     = wide_be[3:0];
          latch_en = 1'b1;
`ifdef MW_POSTED_WRITE_EN
          wf_d     = 1'b1;
`endif
        end
      end
      BEAT1: begin
        if (bus.bus_ack) begin
          if (cross_q) begin
            state_d = BEAT2;
            addr_d  = hi_addr_q;
            data_d  = hi_data_q;
            be_d    = hi_be_q;
          end else begin
            state_d = DONE;
            req_d   = 1'b0;
            be_d    = 4'b0000;
`ifndef MW_POSTED_WRITE_EN
            wf_d    = 1'b1;
`endif
          end
        end
      end
      BEAT2: begin
        if (bus.bus_ack) begin
          state_d = DONE;
          req_d   = 1'b0;
          be_d    = 4'b0000;
`ifndef MW_POSTED_WRITE_EN
          wf_d    = 1'b1;
`endif
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy_d = (state_d == BEAT1) || (state_d == BEAT2);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      be_q    <= 4'b0000;
      wf_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      be_q    <= be_d;
      wf_q    <= wf_d;
      busy_q  <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_addr_q <= '0;
      hi_data_q <= '0;
      hi_be_q   <= 4'b0000;
      cross_q   <= 1'b0;
    end else if (latch_en) begin
      hi_addr_q <= aligned + ADDR_W'(4);
      hi_data_q <= wide_data[2*DATA_W-1:DATA_W];
      hi_be_q   <= wide_be[7:4];
      cross_q   <= cross_in;
    end
  end

  assign bus.bus_req       = req_q;
  assign bus.bus_addr      = addr_q;
  assign bus.bus_data      = data_q;
  assign bus.bus_be        = be_q;
  assign st.write_finished = wf_q;
  assign st.wr_busy        = busy_q;

endmodule

// File: tb/tb_mw_mem_write_ctrl.sv
// Directed bench for mw_mem_write_ctrl: beat split, handshake holds,
// completion timing, reset abort and (if enabled) posted completion.
module tb_mw_mem_write_ctrl;

`ifdef MW_POSTED_WRITE_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   ncmp = 0;
  int   nerr = 0;

  mw_store_if st ();
  mw_bus_if   bus ();

  mw_mem_write_ctrl dut (
    .clk (clk),
    .rst (rst),
    .st  (st),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    ncmp++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_beat(input string tag, input logic [31:0] ea,
                          input logic [31:0] ed, input logic [3:0] eb);
    chk({tag, "_req"}, bus.bus_req, 1);
    chk({tag, "_addr"}, bus.bus_addr, ea);
    chk({tag, "_be"}, bus.bus_be, eb);
    chk({tag, "_data"}, bus.bus_data, ed);
    chk({tag, "_busy"}, st.wr_busy, 1);
  endtask

  task automatic do_store(
    input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
    input int w1, input int w2,
    input logic [31:0] ea1, input logic [31:0] ed1, input logic [3:0] eb1,
    input bit cr,
    input logic [31:0] ea2, input logic [31:0] ed2, input logic [3:0] eb2,
    input bit hold
  );
    st.v_mem_we = 1'b1;
    st.wr_addr  = a;
    st.wr_data  = d;
    st.wr_size  = sz;
    bus.bus_ack = 1'b0;
    cyc();
    chk_beat("b1", ea1, ed1, eb1);
    chk("acc_wf", st.write_finished, POSTED);
    if (POSTED && !hold) st.v_mem_we = 1'b0;
    repeat (w1) begin
      cyc();
      chk_beat("b1_wait", ea1, ed1, eb1);
      chk("b1_wait_wf", st.write_finished, 0);
    end
    bus.bus_ack = 1'b1;
    cyc();
    bus.bus_ack = 1'b0;
    if (cr) begin
      chk_beat("b2", ea2, ed2, eb2);
      chk("b2_wf", st.write_finished, 0);
      repeat (w2) begin
        cyc();
        chk_beat("b2_wait", ea2, ed2, eb2);
        chk("b2_wait_wf", st.write_finished, 0);
      end
      bus.bus_ack = 1'b1;
      cyc();
      bus.bus_ack = 1'b0;
    end
    chk("done_req", bus.bus_req, 0);
    chk("done_wf", st.write_finished, !POSTED);
    chk("done_busy", st.wr_busy, 0);
    if (!hold) st.v_mem_we = 1'b0;
    cyc();
    chk("idle_req", bus.bus_req, 0);
    chk("idle_wf", st.write_finished, 0);
  endtask

  initial begin
    st.v_mem_we = 1'b0;
    st.wr_addr  = '0;
    st.wr_data  = '0;
    st.wr_size  = 2'd0;
    bus.bus_ack = 1'b0;
    rst = 1'b1;
    cyc();
    cyc();
    chk("rst_req", bus.bus_req, 0);
    chk("rst_addr", bus.bus_addr, 0);
    chk("rst_data", bus.bus_data, 0);
    chk("rst_be", bus.bus_be, 0);
    chk("rst_wf", st.write_finished, 0);
    chk("rst_busy", st.wr_busy, 0);
    rst = 1'b0;

    // stray ack while idle must not start anything
    bus.bus_ack = 1'b1;
    cyc();
    bus.bus_ack = 1'b0;
    chk("stray_req", bus.bus_req, 0);
    chk("stray_wf", st.write_finished, 0);

    // aligned word
    do_store(32'h1000, 32'hDEADBEEF, 2'd2, 0, 0,
             32'h1000, 32'hDEADBEEF, 4'b1111, 1'b0,
             32'h0, 32'h0, 4'b0, 1'b0);
    // halfword crossing at 0x1003
    do_store(32'h1003, 32'h0000ABCD, 2'd1, 0, 0,
             32'h1000, 32'hCD000000, 4'b1000, 1'b1,
             32'h1004, 32'h000000AB, 4'b0001, 1'b0);
    // byte with three wait cycles
    do_store(32'h2002, 32'h0000005A, 2'd0, 3, 0,
             32'h2000, 32'h005A0000, 4'b0100, 1'b0,
             32'h0, 32'h0, 4'b0, 1'b0);
    // word crossing, waits on both beats
    do_store(32'h3001, 32'h11223344, 2'd2, 1, 2,
             32'h3000, 32'h22334400, 4'b1110, 1'b1,
             32'h3004, 32'h00000011, 4'b0001, 1'b0);
    // size 3 acts as a word
    do_store(32'h4000, 32'hCAFEF00D, 2'd3, 0, 0,
             32'h4000, 32'hCAFEF00D, 4'b1111, 1'b0,
             32'h0, 32'h0, 4'b0, 1'b0);
    // halfword at top of space, second beat wraps to 0
    do_store(32'hFFFFFFFF, 32'h00001234, 2'd1, 0, 0,
             32'hFFFFFFFC, 32'h34000000, 4'b1000, 1'b1,
             32'h00000000, 32'h00000012, 4'b0001, 1'b0);
    // halfword ending exactly at lane 3: no crossing
    do_store(32'h5002, 32'h0000BEEF, 2'd1, 0, 0,
             32'h5000, 32'hBEEF0000, 4'b1100, 1'b0,
             32'h0, 32'h0, 4'b0, 1'b0);

    // v_mem_we held through DONE, then next store right away
    do_store(32'h6000, 32'h01020304, 2'd2, 0, 0,
             32'h6000, 32'h01020304, 4'b1111, 1'b0,
             32'h0, 32'h0, 4'b0, 1'b1);
    do_store(32'h6005, 32'h000000EE, 2'd0, 0, 0,
             32'h6004, 32'h0000EE00, 4'b0010, 1'b0,
             32'h0, 32'h0, 4'b0, 1'b0);

    // reset while waiting in beat 2
    st.v_mem_we = 1'b1;
    st.wr_addr  = 32'h7003;
    st.wr_data  = 32'h0000A55A;
    st.wr_size  = 2'd1;
    cyc();
    chk_beat("r_b1", 32'h7000, 32'h5A000000, 4'b1000);
    bus.bus_ack = 1'b1;
    cyc();
    bus.bus_ack = 1'b0;
    chk_beat("r_b2", 32'h7004, 32'h000000A5, 4'b0001);
    cyc();
    chk("r_b2_hold", bus.bus_req, 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    st.v_mem_we = 1'b0;
    chk("r_req", bus.bus_req, 0);
    chk("r_be", bus.bus_be, 0);
    chk("r_wf", st.write_finished, 0);
    chk("r_busy", st.wr_busy, 0);
    bus.bus_ack = 1'b1;
    cyc();
    bus.bus_ack = 1'b0;
    chk("r_late_req", bus.bus_req, 0);
    chk("r_late_wf", st.write_finished, 0);
    chk("r_late_busy", st.wr_busy, 0);

    do_store(32'h8000, 32'h55AA55AA, 2'd2, 0, 0,
             32'h8000, 32'h55AA55AA, 4'b1111, 1'b0,
             32'h0, 32'h0, 4'b0, 1'b0);

`ifdef MW_POSTED_WRITE_EN
    // second store queued behind a posted one
    st.v_mem_we = 1'b1;
    st.wr_addr  = 32'h9000;
    st.wr_data  = 32'h13579BDF;
    st.wr_size  = 2'd2;
    cyc();
    chk_beat("p_a", 32'h9000, 32'h13579BDF, 4'b1111);
    chk("p_a_wf", st.write_finished, 1);
    st.wr_addr = 32'h9100;
    st.wr_data = 32'h2468ACE0;
    cyc();
    chk_beat("p_a_wait", 32'h9000, 32'h13579BDF, 4'b1111);
    chk("p_a_wait_wf", st.write_finished, 0);
    bus.bus_ack = 1'b1;
    cyc();
    bus.bus_ack = 1'b0;
    chk("p_done_req", bus.bus_req, 0);
    chk("p_done_wf", st.write_finished, 0);
    chk("p_done_busy", st.wr_busy, 0);
    cyc();
    chk("p_idle_req", bus.bus_req, 0);
    cyc();
    chk_beat("p_b", 32'h9100, 32'h2468ACE0, 4'b1111);
    chk("p_b_wf", st.write_finished, 1);
    st.v_mem_we = 1'b0;
    bus.bus_ack = 1'b1;
    cyc();
    bus.bus_ack = 1'b0;
    chk("p_b_done_req", bus.bus_req, 0);
    chk("p_b_done_wf", st.write_finished, 0);
    cyc();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
